univ_shift_reg: RTL

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 94 +++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/shift/load modes and a counted burst shift.
// Define UNIV_SHIFT_REG_ROTATE_EN to add the rotate modes (S=100/101).
module univ_shift_reg #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             EN,
  input  logic [2:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  input  logic [CW-1:0]    CNT,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CW-1:0] WMAX = CW'(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [CW-1:0]    cnt_clamp;
  logic             dir, dir_n;

  assign cnt_clamp = (CNT > WMAX) ? WMAX : CNT;

  always_ff @(posedge CP) begin
    if (CR) begin
      state <= IDLE;
      q_r   <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_n;
      q_r   <= q_n;
      cnt   <= cnt_n;
      dir   <= dir_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q_r;
    cnt_n   = cnt;
    dir_n   = dir;
    if (EN) begin
      unique case (state)
        IDLE: begin
          unique case (S)
            3'b000: ;
            3'b001: q_n = {q_r[WIDTH-2:0], DSR};
            3'b010: q_n = {DSL, q_r[WIDTH-1:1]};
            3'b011: q_n = D;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            3'b100: q_n = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            3'b101: q_n = {q_r[0], q_r[WIDTH-1:1]};
`else
            3'b100, 3'b101: ;
`endif
            3'b110, 3'b111: begin
              // accept edge only latches; shifting starts next edge
              dir_n   = S[0];
              cnt_n   = cnt_clamp;
              state_n = (cnt_clamp == '0) ? FIN : RUN;
            end
            default: ;
          endcase
        end
        RUN: begin
          q_n   = dir ? {DSL, q_r[WIDTH-1:1]}
                      : {q_r[WIDTH-2:0], DSR};
          cnt_n = cnt - CW'(1);
          if (cnt == CW'(1)) state_n = FIN;
        end
        FIN:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign Q    = q_r;
  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);

endmodule
